// File: rtl/pipeline_ctrl_if.sv
// ============================================================================
// Module      : pipeline_ctrl_if
// Description : Hazard-information inputs and register-bank control outputs
//               exchanged between the pipeline datapath and pipeline_ctrl.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface pipeline_ctrl_if #(
  parameter int REG_ADDR_WIDTH = 5
);
  logic [REG_ADDR_WIDTH-1:0] i_id_rs1;
  logic [REG_ADDR_WIDTH-1:0] i_id_rs2;
  logic                      i_id_uses_rs1;
  logic                      i_id_uses_rs2;
  logic                      i_ex_is_load;
  logic [REG_ADDR_WIDTH-1:0] i_ex_rd;
  logic                      i_ex_is_mul;
  logic                      i_ex_branch_taken;
  logic                      i_mem_req;
  logic                      i_mem_ready;

  logic                      o_pc_en;
  logic                      o_if_id_en;
  logic                      o_id_ex_en;
  logic                      o_ex_mem_en;
  logic                      o_mem_wb_en;
  logic                      o_if_id_flush;
  logic                      o_id_ex_flush;
  logic                      o_ex_mem_flush;
  logic [1:0]                o_stall_cause;

  // Datapath side: reports hazards, consumes enables/flushes.
  modport master (
    output i_id_rs1, i_id_rs2, i_id_uses_rs1, i_id_uses_rs2,
    output i_ex_is_load, i_ex_rd, i_ex_is_mul, i_ex_branch_taken,
    output i_mem_req, i_mem_ready,
    input  o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en,
    input  o_if_id_flush, o_id_ex_flush, o_ex_mem_flush, o_stall_cause
  );

  modport slave (
    input  i_id_rs1, i_id_rs2, i_id_uses_rs1, i_id_uses_rs2,
    input  i_ex_is_load, i_ex_rd, i_ex_is_mul, i_ex_branch_taken,
    input  i_mem_req, i_mem_ready,
    output o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en,
    output o_if_id_flush, o_id_ex_flush, o_ex_mem_flush, o_stall_cause
  );
endinterface

`default_nettype wire

// File: rtl/pipeline_ctrl.sv
// ============================================================================
// Module      : pipeline_ctrl
// Description : Hazard/stall controller for a 5-stage pipeline: load-use,
//               taken branch, multi-cycle multiply and memory wait states.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module pipeline_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MUL_LATENCY    = 3
) (
  input  wire logic          clk,
  input  wire logic          rst,
  pipeline_ctrl_if.slave     bus
);

  localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;
  localparam logic [CNT_W-1:0] C_MUL_RELOAD =
      CNT_W'((MUL_LATENCY > 1) ? (MUL_LATENCY - 2) : 0);
  localparam logic C_MUL_STALLS = 1'((MUL_LATENCY > 1) ? 1 : 0);

  localparam logic [1:0] C_CAUSE_NONE = 2'd0;
  localparam logic [1:0] C_CAUSE_LU   = 2'd1;
  localparam logic [1:0] C_CAUSE_MUL  = 2'd2;
  localparam logic [1:0] C_CAUSE_MEM  = 2'd3;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic              mul_busy_q, mul_busy_d;
  logic [CNT_W-1:0]  mul_cnt_q, mul_cnt_d;

  logic [REG_ADDR_WIDTH-1:0] w_rs1, w_rs2, w_rd;
  logic w_mem_stall, w_mul_done, w_mul_stall, w_load_use, w_ex_advance;
  logic w_rs1_hit, w_rs2_hit;

  assign w_rs1 = bus.i_id_rs1;
  assign w_rs2 = bus.i_id_rs2;
  assign w_rd  = bus.i_ex_rd;

  assign w_mem_stall  = bus.i_mem_req & ~bus.i_mem_ready;
  assign w_mul_done   = mul_busy_q & (mul_cnt_q == '0);
  assign w_mul_stall  = bus.i_ex_is_mul & C_MUL_STALLS & ~w_mul_done;
  assign w_rs1_hit    = bus.i_id_uses_rs1 & (w_rs1 == w_rd);
  assign w_rs2_hit    = bus.i_id_uses_rs2 & (w_rs2 == w_rd);
  assign w_load_use   = bus.i_ex_is_load & (w_rd != '0) & (w_rs1_hit | w_rs2_hit);
  assign w_ex_advance = ~w_mem_stall & ~w_mul_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      mul_busy_q <= 1'b0;
      mul_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      mul_busy_q <= mul_busy_d;
      mul_cnt_q  <= mul_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mul_busy_d = mul_busy_q;
    mul_cnt_d  = mul_cnt_q;

    case (state_q)
      RUN:      if (w_mem_stall) state_d = MEM_WAIT;
      MEM_WAIT: if (bus.i_mem_ready) state_d = RUN;
      default:  state_d = RUN;
    endcase

    // The multiplier is free-running: the count drains even while frozen.
    if (mul_busy_q) begin
      if (mul_cnt_q != '0) mul_cnt_d = mul_cnt_q - 1'b1;
      if (w_ex_advance) mul_busy_d = 1'b0;
    end else if (bus.i_ex_is_mul && C_MUL_STALLS) begin
      mul_busy_d = 1'b1;
      mul_cnt_d  = C_MUL_RELOAD;
    end
  end

  always_comb begin
    bus.o_pc_en        = 1'b1;
    bus.o_if_id_en     = 1'b1;
    bus.o_id_ex_en     = 1'b1;
    bus.o_ex_mem_en    = 1'b1;
    bus.o_mem_wb_en    = 1'b1;
    bus.o_if_id_flush  = 1'b0;
    bus.o_id_ex_flush  = 1'b0;
    bus.o_ex_mem_flush = 1'b0;
    bus.o_stall_cause  = C_CAUSE_NONE;

    if (rst) begin
      bus.o_pc_en        = 1'b0;
      bus.o_if_id_en     = 1'b0;
      bus.o_id_ex_en     = 1'b0;
      bus.o_ex_mem_en    = 1'b0;
      bus.o_mem_wb_en    = 1'b0;
      bus.o_if_id_flush  = 1'b1;
      bus.o_id_ex_flush  = 1'b1;
      bus.o_ex_mem_flush = 1'b1;
    end else if (w_mem_stall) begin
      bus.o_pc_en        = 1'b0;
      bus.o_if_id_en     = 1'b0;
      bus.o_id_ex_en     = 1'b0;
      bus.o_ex_mem_en    = 1'b0;
      bus.o_mem_wb_en    = 1'b0;
      bus.o_stall_cause  = C_CAUSE_MEM;
    end else if (w_mul_stall) begin
      bus.o_pc_en        = 1'b0;
      bus.o_if_id_en     = 1'b0;
      bus.o_id_ex_en     = 1'b0;
      bus.o_ex_mem_flush = 1'b1;
      bus.o_stall_cause  = C_CAUSE_MUL;
    end else if (bus.i_ex_branch_taken) begin
      // Taken branch discards the ID instruction, so it outranks load-use.
      bus.o_if_id_flush  = 1'b1;
      bus.o_id_ex_flush  = 1'b1;
    end else if (w_load_use) begin
      bus.o_pc_en        = 1'b0;
      bus.o_if_id_en     = 1'b0;
      bus.o_id_ex_flush  = 1'b1;
      bus.o_stall_cause  = C_CAUSE_LU;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Directed self-checking bench for pipeline_ctrl (MUL_LATENCY=3).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_ctrl;

  // Packed view: {pc,if_id,id_ex,ex_mem,mem_wb en, if_id,id_ex,ex_mem flush, cause}
  localparam logic [9:0] C_RST = 10'b00000_111_00;
  localparam logic [9:0] C_RUN = 10'b11111_000_00;
  localparam logic [9:0] C_LU  = 10'b00111_010_01;
  localparam logic [9:0] C_MUL = 10'b00011_001_10;
  localparam logic [9:0] C_MEM = 10'b00000_000_11;
  localparam logic [9:0] C_BR  = 10'b11111_110_00;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_pass = 0;
  int   n_chk  = 0;
  logic [9:0] sb_q[$];

  always #5 clk = ~clk;

  pipeline_ctrl_if #(.REG_ADDR_WIDTH(5)) bus ();

  pipeline_ctrl #(.REG_ADDR_WIDTH(5), .MUL_LATENCY(3)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [9:0] observe();
    return {bus.o_pc_en, bus.o_if_id_en, bus.o_id_ex_en, bus.o_ex_mem_en,
            bus.o_mem_wb_en, bus.o_if_id_flush, bus.o_id_ex_flush,
            bus.o_ex_mem_flush, bus.o_stall_cause};
  endfunction

  task automatic idle();
    bus.i_id_rs1 = '0;  bus.i_id_rs2 = '0;
    bus.i_id_uses_rs1 = 1'b0;  bus.i_id_uses_rs2 = 1'b0;
    bus.i_ex_is_load = 1'b0;  bus.i_ex_rd = '0;
    bus.i_ex_is_mul = 1'b0;  bus.i_ex_branch_taken = 1'b0;
    bus.i_mem_req = 1'b0;  bus.i_mem_ready = 1'b0;
  endtask

  // Push the expectation, sample mid-cycle, then let the clock edge pass.
  task automatic cyc(input logic [9:0] exp, input string tag);
    logic [9:0] obs, want;
    sb_q.push_back(exp);
    @(negedge clk);
    obs  = observe();
    want = sb_q.pop_front();
    n_chk++;
    assert (obs === want) n_pass++;
    else $error("FAIL %s: observed=%b expected=%b", tag, obs, want);
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk); #1;

    cyc(C_RST, "reset0");
    cyc(C_RST, "reset1");
    rst = 1'b0;
    cyc(C_RUN, "post_reset_idle");

    // Load-use on rs2 and its rd=0 / unused-source counterparts
    bus.i_ex_is_load = 1'b1; bus.i_ex_rd = 5'd5;
    bus.i_id_rs2 = 5'd5; bus.i_id_uses_rs2 = 1'b1;
    cyc(C_LU, "load_use_rs2");
    idle();
    cyc(C_RUN, "load_use_bubble_done");
    bus.i_ex_is_load = 1'b1; bus.i_ex_rd = 5'd0;
    bus.i_id_rs2 = 5'd0; bus.i_id_uses_rs2 = 1'b1;
    cyc(C_RUN, "load_use_rd0");
    idle();
    bus.i_ex_is_load = 1'b1; bus.i_ex_rd = 5'd7;
    bus.i_id_rs1 = 5'd7; bus.i_id_uses_rs1 = 1'b0;
    cyc(C_RUN, "load_use_rs1_unused");
    bus.i_id_uses_rs1 = 1'b1;
    cyc(C_LU, "load_use_rs1");
    idle();

    // Back-to-back multiplies
    bus.i_ex_is_mul = 1'b1;
    cyc(C_MUL, "mul1_c0");
    cyc(C_MUL, "mul1_c1");
    cyc(C_RUN, "mul1_adv");
    cyc(C_MUL, "mul2_c0");
    cyc(C_MUL, "mul2_c1");
    cyc(C_RUN, "mul2_adv");
    idle();
    cyc(C_RUN, "mul_idle");

    // Memory wait of three cycles, then same-cycle ready
    bus.i_mem_req = 1'b1; bus.i_mem_ready = 1'b0;
    cyc(C_MEM, "mem_w0");
    cyc(C_MEM, "mem_w1");
    cyc(C_MEM, "mem_w2");
    bus.i_mem_ready = 1'b1;
    cyc(C_RUN, "mem_ready");
    cyc(C_RUN, "mem_req_ready_run");
    idle();

    // Branch beats load-use
    bus.i_ex_branch_taken = 1'b1;
    bus.i_ex_is_load = 1'b1; bus.i_ex_rd = 5'd3;
    bus.i_id_rs1 = 5'd3; bus.i_id_uses_rs1 = 1'b1;
    cyc(C_BR, "branch_vs_load_use");
    idle();

    // Branch held across a memory stall
    bus.i_ex_branch_taken = 1'b1; bus.i_mem_req = 1'b1;
    cyc(C_MEM, "branch_in_mem0");
    cyc(C_MEM, "branch_in_mem1");
    bus.i_mem_ready = 1'b1;
    cyc(C_BR, "branch_after_mem");
    idle();

    // Branch held across a multiply stall
    bus.i_ex_branch_taken = 1'b1; bus.i_ex_is_mul = 1'b1;
    cyc(C_MUL, "branch_in_mul0");
    cyc(C_MUL, "branch_in_mul1");
    cyc(C_BR, "branch_after_mul");
    idle();
    cyc(C_RUN, "idle_after_branch_mul");

    // Memory stall overlapping the second multiply cycle
    bus.i_ex_is_mul = 1'b1;
    cyc(C_MUL, "mulmem_c0");
    bus.i_mem_req = 1'b1;
    cyc(C_MEM, "mulmem_c1");
    cyc(C_MEM, "mulmem_c2");
    bus.i_mem_ready = 1'b1;
    cyc(C_RUN, "mulmem_adv");
    idle();
    cyc(C_RUN, "mulmem_idle");

    // Reset in the middle of a multiply abandons it
    bus.i_ex_is_mul = 1'b1;
    cyc(C_MUL, "mulrst_c0");
    rst = 1'b1;
    cyc(C_RST, "mulrst_reset");
    rst = 1'b0;
    cyc(C_MUL, "mulrst_restart0");
    cyc(C_MUL, "mulrst_restart1");
    cyc(C_RUN, "mulrst_adv");
    idle();

    // Reset in the middle of a memory wait
    bus.i_mem_req = 1'b1;
    cyc(C_MEM, "memrst_w0");
    rst = 1'b1;
    cyc(C_RST, "memrst_reset");
    rst = 1'b0;
    idle();
    cyc(C_RUN, "memrst_idle");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
